// File: rtl/regfile_pkg.sv
// Shared constants and types for the generic register file: special index map,
// status bit positions and scrub FSM state encoding.
package regfile_pkg;

    localparam int unsigned IDX_ZERO   = 0;
    localparam int unsigned IDX_STATUS = 1;
    localparam int unsigned IDX_PC     = 2;
    localparam int unsigned IDX_EPC    = 3;
    localparam int unsigned IDX_GPR0   = 4;

    localparam int unsigned ST_KMODE = 0;
    localparam int unsigned ST_INTEN = 1;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/regfile_status.sv
// STATUS / SSTAT / EPC registers with interrupt entry/return, kernel-mode write
// protection and the update priority between them.
module regfile_status
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_din,
    input  logic            i_we_status,
    input  logic            i_we_epc,
    input  logic            i_ir_tsf,
    input  logic            i_ir_ret,
    input  logic            i_ks,
    output logic [XLEN-1:0] o_status,
    output logic [XLEN-1:0] o_epc,
    output logic [XLEN-1:0] o_status_nxt_c,
    output logic            o_status_acc_c,
    output logic            o_epc_acc_c
);

    logic [XLEN-1:0] r_status;
    logic [XLEN-1:0] r_sstat;
    logic [XLEN-1:0] r_epc;
    logic [XLEN-1:0] w_status_nxt;
    logic            w_status_acc;
    logic            w_epc_acc;

    // Interrupt entry beats return beats software write; ks is applied last.
    always_comb begin
        w_status_nxt = r_status;
        w_status_acc = 1'b0;
        if (i_ir_tsf) begin
            w_status_nxt[ST_INTEN] = 1'b0;
            w_status_nxt[ST_KMODE] = 1'b1;
        end else if (i_ir_ret) begin
            w_status_nxt = r_sstat;
        end else if (i_we_status && r_status[ST_KMODE]) begin
            w_status_nxt = i_din;
            w_status_acc = 1'b1;
        end
        if (i_ks) begin
            w_status_nxt[ST_KMODE] = 1'b1;
        end
    end

    assign w_epc_acc = i_we_epc && !i_ir_tsf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_status <= XLEN'(1);
            r_sstat  <= XLEN'(1);
            r_epc    <= '0;
        end else begin
            r_status <= w_status_nxt;
            if (i_ir_tsf) begin
                r_sstat <= r_status;
                r_epc   <= i_pc;
            end else if (w_epc_acc) begin
                r_epc <= i_din;
            end
        end
    end

    assign o_status       = r_status;
    assign o_epc          = r_epc;
    assign o_status_nxt_c = w_status_nxt;
    assign o_status_acc_c = w_status_acc;
    assign o_epc_acc_c    = w_epc_acc;

endmodule

// File: rtl/regfile_gen.sv
// Generic register file: zero/PC/STATUS/EPC special indices, general registers
// cleared by a post-reset scrub, two combinational read ports with optional bypass.
module regfile_gen
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter bit          BYPASS = 1'b1,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] din,
    input  logic            c_we,
    input  logic [AW-1:0]   csel,
    input  logic [AW-1:0]   asel,
    input  logic [AW-1:0]   bsel,
    output logic [XLEN-1:0] aout,
    output logic [XLEN-1:0] bout,
    input  logic [XLEN-1:0] pc,
    input  logic            ir_tsf,
    input  logic            ir_ret,
    input  logic            ks,
    output logic [XLEN-1:0] ir,
    output logic            int_en,
    output logic            kmode,
    output logic            busy
);

    fsm_state_t      r_state;
    logic [AW-1:0]   r_scrub;
    logic            r_busy;
    logic [XLEN-1:0] r_mem [IDX_GPR0:NREGS-1];

    logic            w_run;
    logic            w_we_status;
    logic            w_we_epc;
    logic            w_gpr_acc;
    logic [XLEN-1:0] w_status;
    logic [XLEN-1:0] w_epc;
    logic [XLEN-1:0] w_status_nxt;
    logic            w_status_acc;
    logic            w_epc_acc;

    assign w_run       = (r_state == RUN);
    assign w_we_status = c_we && w_run && (csel == AW'(IDX_STATUS));
    assign w_we_epc    = c_we && w_run && (csel == AW'(IDX_EPC));
    assign w_gpr_acc   = c_we && w_run && (csel >= AW'(IDX_GPR0));

    regfile_status #(.XLEN(XLEN)) u_status (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_pc           (pc),
        .i_din          (din),
        .i_we_status    (w_we_status),
        .i_we_epc       (w_we_epc),
        .i_ir_tsf       (ir_tsf),
        .i_ir_ret       (ir_ret),
        .i_ks           (ks),
        .o_status       (w_status),
        .o_epc          (w_epc),
        .o_status_nxt_c (w_status_nxt),
        .o_status_acc_c (w_status_acc),
        .o_epc_acc_c    (w_epc_acc)
    );

    // Scrub FSM: one general register cleared per cycle, then RUN until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= INIT;
            r_scrub <= AW'(IDX_GPR0);
            r_busy  <= 1'b1;
        end else if (r_state == INIT) begin
            if (r_scrub == AW'(NREGS - 1)) begin
                r_state <= RUN;
                r_busy  <= 1'b0;
            end else begin
                r_scrub <= r_scrub + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!w_run) begin
            r_mem[r_scrub] <= '0;
        end else if (w_gpr_acc) begin
            r_mem[csel] <= din;
        end
    end

    function automatic logic [XLEN-1:0] rd_port(input logic [AW-1:0] sel);
        logic [XLEN-1:0] v;
        v = '0;
        if (sel == AW'(IDX_ZERO)) begin
            v = '0;
        end else if (sel == AW'(IDX_STATUS)) begin
            v = (BYPASS && w_status_acc) ? w_status_nxt : w_status;
        end else if (sel == AW'(IDX_PC)) begin
            v = pc;
        end else if (sel == AW'(IDX_EPC)) begin
            v = (BYPASS && w_epc_acc) ? din : w_epc;
        end else if (!w_run) begin
            v = '0;
        end else if (BYPASS && w_gpr_acc && (csel == sel)) begin
            v = din;
        end else begin
            v = r_mem[sel];
        end
        return v;
    endfunction

    always_comb begin
        aout = rd_port(asel);
        bout = rd_port(bsel);
    end

    assign ir     = w_epc;
    assign int_en = w_status[ST_INTEN];
    assign kmode  = w_status[ST_KMODE];
    assign busy   = r_busy;

endmodule

// File: tb/tb_regfile_gen.sv
// Directed bench for regfile_gen: one bypassing and one non-bypassing instance
// share the same stimulus; every expected value is hand-computed.
module tb_regfile_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] din;
    logic [31:0] pc;
    logic        c_we;
    logic [4:0]  csel;
    logic [4:0]  asel;
    logic [4:0]  bsel;
    logic        ir_tsf;
    logic        ir_ret;
    logic        ks;

    logic [31:0] aout, bout, ir;
    logic        int_en, kmode, busy;
    logic [31:0] aout0, bout0, ir0;
    logic        int_en0, kmode0, busy0;

    int n_assert = 0;
    int n_fail   = 0;
    int cnt;

    always #5 clk = ~clk;

    regfile_gen #(.XLEN(32), .NREGS(32), .BYPASS(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .din(din), .c_we(c_we), .csel(csel),
        .asel(asel), .bsel(bsel), .aout(aout), .bout(bout), .pc(pc),
        .ir_tsf(ir_tsf), .ir_ret(ir_ret), .ks(ks), .ir(ir),
        .int_en(int_en), .kmode(kmode), .busy(busy)
    );

    regfile_gen #(.XLEN(32), .NREGS(32), .BYPASS(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .din(din), .c_we(c_we), .csel(csel),
        .asel(asel), .bsel(bsel), .aout(aout0), .bout(bout0), .pc(pc),
        .ir_tsf(ir_tsf), .ir_ret(ir_ret), .ks(ks), .ir(ir0),
        .int_en(int_en0), .kmode(kmode0), .busy(busy0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        c_we   = 1'b0;
        ir_tsf = 1'b0;
        ir_ret = 1'b0;
        ks     = 1'b0;
    endtask

    // Counts edges until busy drops, bounded at 40.
    task automatic wait_run(input string tag);
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            tick;
            cnt++;
        end
        check(tag, 32'(cnt), 32'd28);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle;
        din  = 32'h0;
        pc   = 32'h40;
        csel = 5'd0;
        asel = 5'd31;
        bsel = 5'd2;
        #12;
        check("rst_ir", ir, 32'h0);
        check("rst_int_en", 32'(int_en), 32'd0);
        check("rst_kmode", 32'(kmode), 32'd1);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_read_r31", aout, 32'h0);
        check("rst_read_pc", bout, 32'h40);

        // Release reset and try an EPC write throughout INIT.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        c_we = 1'b1; csel = 5'd3; din = 32'hDEAD;
        wait_run("init_busy_cycles");
        idle;
        #1;
        check("init_epc_write_ignored", ir, 32'h0);
        check("busy0_after_init", 32'(busy0), 32'd0);
        check("run_read_r31", aout, 32'h0);
        check("run_read_r31_nobyp", aout0, 32'h0);
        check("run_kmode", 32'(kmode), 32'd1);
        check("run_int_en", 32'(int_en), 32'd0);

        // Kernel write of STATUS, then a dropped user-mode write.
        c_we = 1'b1; csel = 5'd1; din = 32'h2; asel = 5'd1;
        #1;
        check("status_write_fwd", aout, 32'h2);
        tick;
        check("status_int_en", 32'(int_en), 32'd1);
        check("status_kmode", 32'(kmode), 32'd0);
        din = 32'h3;
        #1;
        check("status_drop_no_fwd", aout, 32'h2);
        tick;
        idle;
        #1;
        check("status_drop_held", aout, 32'h2);
        check("status_drop_kmode", 32'(kmode), 32'd0);

        // Index 0 and index 2 ignore writes.
        c_we = 1'b1; csel = 5'd0; din = 32'hFF; asel = 5'd0; bsel = 5'd2; pc = 32'h100;
        #1;
        check("zero_no_fwd", aout, 32'h0);
        check("pc_alias", bout, 32'h100);
        csel = 5'd2;
        #1;
        check("pc_write_no_fwd", bout, 32'h100);
        tick;
        idle;
        #1;
        check("zero_after_write", aout, 32'h0);

        // General register bypass versus stored value.
        c_we = 1'b1; csel = 5'd5; din = 32'hA5A5A5A5; asel = 5'd5;
        #1;
        check("gpr_bypass", aout, 32'hA5A5A5A5);
        check("gpr_nobypass_old", aout0, 32'h0);
        tick;
        idle;
        #1;
        check("gpr_stored", aout, 32'hA5A5A5A5);
        check("gpr_stored_nobyp", aout0, 32'hA5A5A5A5);

        // Interrupt entry overrides a same-cycle EPC write, then return.
        pc = 32'h100; ir_tsf = 1'b1; c_we = 1'b1; csel = 5'd3; din = 32'hDEAD; bsel = 5'd3;
        #1;
        check("epc_no_fwd_on_tsf", bout, 32'h0);
        tick;
        idle;
        asel = 5'd1;
        #1;
        check("tsf_epc", ir, 32'h100);
        check("tsf_status", aout, 32'h1);
        check("tsf_int_en", 32'(int_en), 32'd0);
        ir_ret = 1'b1;
        tick;
        idle;
        #1;
        check("ret_status", aout, 32'h2);
        check("ret_epc_kept", ir, 32'h100);

        // ks alone, then full same-edge priority collision.
        ks = 1'b1;
        tick;
        idle;
        #1;
        check("ks_status", aout, 32'h3);
        c_we = 1'b1; csel = 5'd1; din = 32'h33;
        tick;
        idle;
        #1;
        check("kernel_write_33", aout, 32'h33);
        ir_tsf = 1'b1; ir_ret = 1'b1; ks = 1'b1; c_we = 1'b1; csel = 5'd1; din = 32'hF0; pc = 32'h200;
        tick;
        idle;
        #1;
        check("collision_status", aout, 32'h31);
        check("collision_epc", ir, 32'h200);
        ir_ret = 1'b1;
        tick;
        idle;
        #1;
        check("collision_ret_sstat", aout, 32'h33);

        c_we = 1'b1; csel = 5'd31; din = 32'h5555; bsel = 5'd31;
        tick;
        idle;
        #1;
        check("r31_stored", bout, 32'h5555);
        check("r31_stored_nobyp", bout0, 32'h5555);

        // Async reset from RUN, then reset again mid-scrub at index 10.
        rst_n = 1'b0;
        #1;
        check("rerst_busy", 32'(busy), 32'd1);
        check("rerst_kmode", 32'(kmode), 32'd1);
        check("rerst_int_en", 32'(int_en), 32'd0);
        check("rerst_ir", ir, 32'h0);
        check("rerst_status", aout, 32'h1);
        #2;
        rst_n = 1'b1;
        repeat (6) tick;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        c_we = 1'b1; csel = 5'd1; din = 32'h2;
        wait_run("rescrub_busy_cycles");
        idle;
        asel = 5'd5; bsel = 5'd31;
        #1;
        check("init_status_write_ignored", 32'(int_en), 32'd0);
        check("init_status_kmode", 32'(kmode), 32'd1);
        check("rescrub_r31", bout, 32'h0);
        check("rescrub_r5", aout, 32'h0);
        check("rescrub_r5_nobyp", aout0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
